// File: rtl/core_seq.sv
// Sequences one full tile on the core's inst bus: weight fetch, kernel load, activation fetch, execute, drain.
// Latency: start is accepted in IDLE, and inst/busy/done are registered, so all actions appear one cycle after the step that decides them.
// Backpressure: xmem reads stall while l0_ready=0; OFIFO pops stall while ofifo_valid=0; start is ignored while busy.
module core_seq #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int addr_bw = 11,
    parameter int len_bw  = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_bw-1:0]       w_base,
    input  logic [addr_bw-1:0]       x_base,
    input  logic [len_bw-1:0]        x_len,
    input  logic [addr_bw-1:0]       p_base,
    input  logic                     l0_ready,
    input  logic                     ofifo_valid,
    output logic [2*addr_bw+11:0]    inst,
    output logic                     busy,
    output logic                     done
);

    localparam int IW = 2*addr_bw + 12;

    localparam int LOAD     = 0;
    localparam int EXECUTE  = 1;
    localparam int L0_WR    = 2;
    localparam int L0_RD    = 3;
    localparam int OFIFO_RD = 6;
    localparam int AX_LO    = 7;
    localparam int WEN_X    = addr_bw + 7;
    localparam int CEN_X    = addr_bw + 8;
    localparam int AP_LO    = addr_bw + 9;
    localparam int WEN_P    = 2*addr_bw + 9;
    localparam int CEN_P    = 2*addr_bw + 10;

    localparam logic [IW-1:0] NOP = (IW'(1) << CEN_P) | (IW'(1) << WEN_P) |
                                    (IW'(1) << CEN_X) | (IW'(1) << WEN_X);

    // Counter must hold x_len = 2^len_bw - 1 plus one, and the kernel-load sequence length.
    localparam int SEQ_MAX = 2*col + row;
    localparam int LEN_MAX = 1 << len_bw;
    localparam int cnt_w   = $clog2(((SEQ_MAX > LEN_MAX) ? SEQ_MAX : LEN_MAX) + 1);

    localparam logic [cnt_w-1:0] ONE      = cnt_w'(1);
    localparam logic [cnt_w-1:0] COL_N    = cnt_w'(col);
    localparam logic [cnt_w-1:0] WKL_LAST = cnt_w'(2*col + row - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WLD   = 3'd1;
    localparam logic [2:0] WKL   = 3'd2;
    localparam logic [2:0] XLD   = 3'd3;
    localparam logic [2:0] EXEC  = 3'd4;
    localparam logic [2:0] DRAIN = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

    logic [2:0]         state, state_nxt;
    logic [cnt_w-1:0]   cnt, cnt_nxt;
    logic [cnt_w-1:0]   wcnt, wcnt_nxt;
    logic [IW-1:0]      inst_nxt;
    logic               busy_nxt, done_nxt;

    logic [addr_bw-1:0] w_base_q, x_base_q, p_base_q;
    logic [len_bw-1:0]  x_len_q;

    logic [cnt_w-1:0]   x_len_ext;
    logic [cnt_w-1:0]   fetch_total;
    logic [addr_bw-1:0] fetch_base;
    logic               rd_on_bus, ofrd_on_bus;

    assign x_len_ext   = cnt_w'(x_len_q);
    assign fetch_total = (state == WLD) ? COL_N : x_len_ext;
    assign fetch_base  = (state == WLD) ? w_base_q : x_base_q;
    // The word currently on the bus tells us what must follow it: l0_wr after a read, a pmem write after a pop.
    assign rd_on_bus   = ~inst[CEN_X];
    assign ofrd_on_bus = inst[OFIFO_RD];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wcnt_nxt  = wcnt;
        inst_nxt  = NOP;
        done_nxt  = 1'b0;
        busy_nxt  = (state != IDLE) || start;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = WLD;
                    cnt_nxt   = '0;
                    wcnt_nxt  = '0;
                end
            end
            WLD, XLD: begin
                inst_nxt[L0_WR] = rd_on_bus;
                if ((cnt < fetch_total) && l0_ready) begin
                    inst_nxt[CEN_X]               = 1'b0;
                    inst_nxt[AX_LO +: addr_bw]    = fetch_base + addr_bw'(cnt);
                    cnt_nxt                       = cnt + ONE;
                end else if ((cnt == fetch_total) && rd_on_bus) begin
                    state_nxt = (state == WLD) ? WKL : EXEC;
                    cnt_nxt   = '0;
                end
            end
            WKL: begin
                if (cnt < COL_N) begin
                    inst_nxt[LOAD]  = 1'b1;
                    inst_nxt[L0_RD] = 1'b1;
                end
                if (cnt == WKL_LAST) begin
                    state_nxt = (x_len_ext == '0) ? DONE : XLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            EXEC: begin
                inst_nxt[L0_RD]   = 1'b1;
                inst_nxt[EXECUTE] = 1'b1;
                if (cnt == x_len_ext - ONE) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            DRAIN: begin
                if (ofrd_on_bus) begin
                    inst_nxt[CEN_P]            = 1'b0;
                    inst_nxt[WEN_P]            = 1'b0;
                    inst_nxt[AP_LO +: addr_bw] = p_base_q + addr_bw'(wcnt);
                    wcnt_nxt                   = wcnt + ONE;
                    if (wcnt == x_len_ext - ONE) state_nxt = DONE;
                end
                if ((cnt < x_len_ext) && ofifo_valid) begin
                    inst_nxt[OFIFO_RD] = 1'b1;
                    cnt_nxt            = cnt + ONE;
                end
            end
            DONE: begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            wcnt     <= '0;
            inst     <= NOP;
            busy     <= 1'b0;
            done     <= 1'b0;
            w_base_q <= '0;
            x_base_q <= '0;
            p_base_q <= '0;
            x_len_q  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            wcnt  <= wcnt_nxt;
            inst  <= inst_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            if ((state == IDLE) && start) begin
                w_base_q <= w_base;
                x_base_q <= x_base;
                p_base_q <= p_base;
                x_len_q  <= x_len;
            end
        end
    end

endmodule

// File: tb/tb_core_seq.sv
// Bench for core_seq: a tile-level model (expected address queues, event counts, ordering rules) checked every cycle.
// Directed tiles cover the basic flow, l0_ready/ofifo_valid stalls, x_len=0, address wrap, mid-tile reset and ignored start.
module tb_core_seq;
    localparam int ROW = 8;
    localparam int COL = 8;
    localparam logic [33:0] NOP = 34'h1_800C_0000;

    logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [10:0] w_base = '0, x_base = '0, x_len = '0, p_base = '0;
    logic        l0_lvl = 1'b1, ofv_lvl = 1'b1, tog_bit = 1'b0, l0_tog = 1'b0, ofv_tog = 1'b0;
    logic        l0_ready, ofifo_valid;
    logic [33:0] inst;
    logic        busy, done;

    assign l0_ready    = l0_tog  ? tog_bit : l0_lvl;
    assign ofifo_valid = ofv_tog ? tog_bit : ofv_lvl;

    core_seq #(.row(ROW), .col(COL), .addr_bw(11), .len_bw(11)) dut (
        .clk(clk), .reset(reset), .start(start),
        .w_base(w_base), .x_base(x_base), .x_len(x_len), .p_base(p_base),
        .l0_ready(l0_ready), .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tog_bit <= ~tog_bit;

    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Tile model: what the tile must do, expressed as address lists and event counts.
    int exp_x[$], exp_p[$], x_obs[$], p_obs[$];
    int cur_len = 0, cyc = 0;
    int n_rd, n_l0w, n_load, n_exec, n_ofrd, n_pw, n_done;
    int last_load_cyc, first_x_cyc, done_cyc, first_exec_cyc, last_exec_cyc;
    logic [33:0] first_rd_word, first_pw_word;
    bit prev_rd = 0, prev_ofrd = 0, prev_l0r = 0, prev_ofv = 0;

    always @(negedge clk) begin
        bit rd, pw;
        cyc++;
        if (!reset) begin
            prev_rd = 0; prev_ofrd = 0; prev_l0r = 0; prev_ofv = 0;
        end else begin
            rd = !inst[19];
            pw = !inst[32];
            if (!busy && !done) begin
                check("idle_nop", inst, NOP);
            end else begin
                check("fixed_bits", {inst[33], inst[31] ^ inst[32], inst[18], inst[5], inst[4]}, 5'b00100);
                check("l0_wr_follows_read", inst[2], prev_rd);
                check("l0_rd_with_load_exec", inst[3], inst[0] | inst[1]);
                if (inst[2]) n_l0w++;
                if (rd) begin
                    check("read_needs_l0_ready", prev_l0r, 1);
                    if (n_rd == 0) first_rd_word = inst;
                    if (n_load > 0 && first_x_cyc < 0) first_x_cyc = cyc;
                    x_obs.push_back(int'(inst[17:7]));
                    checks++;
                    if (exp_x.size() == 0) begin
                        failures++;
                        $display("FAIL extra_read: got addr %0d expected no read", inst[17:7]);
                    end else begin
                        int e;
                        e = exp_x.pop_front();
                        if (int'(inst[17:7]) != e) begin
                            failures++;
                            $display("FAIL xaddr: got %0d expected %0d", inst[17:7], e);
                        end
                    end
                    n_rd++;
                end
                if (inst[0]) begin
                    n_load++;
                    last_load_cyc = cyc;
                end
                if (inst[1]) begin
                    if (n_exec == 0) begin
                        first_exec_cyc = cyc;
                        check("exec_after_fetch", n_l0w, COL + cur_len);
                    end
                    n_exec++;
                    last_exec_cyc = cyc;
                end
                if (inst[6]) begin
                    check("ofifo_rd_needs_valid", prev_ofv, 1);
                    if (n_ofrd == 0) check("drain_after_exec", n_exec, cur_len);
                    n_ofrd++;
                end
                if (pw) begin
                    check("pmem_write_follows_pop", prev_ofrd, 1);
                    if (n_pw == 0) first_pw_word = inst;
                    p_obs.push_back(int'(inst[30:20]));
                    checks++;
                    if (exp_p.size() == 0) begin
                        failures++;
                        $display("FAIL extra_pmem_write: got addr %0d expected no write", inst[30:20]);
                    end else begin
                        int e;
                        e = exp_p.pop_front();
                        if (int'(inst[30:20]) != e) begin
                            failures++;
                            $display("FAIL paddr: got %0d expected %0d", inst[30:20], e);
                        end
                    end
                    n_pw++;
                end
                if (done) begin
                    n_done++;
                    done_cyc = cyc;
                    check("done_busy", busy, 1);
                    check("done_inst_nop", inst, NOP);
                end
            end
            prev_rd   = rd;
            prev_ofrd = inst[6];
            prev_l0r  = l0_ready;
            prev_ofv  = ofifo_valid;
        end
    end

    task automatic begin_tile(input int w, input int x, input int len, input int p);
        @(posedge clk); #1;
        w_base = 11'(w); x_base = 11'(x); x_len = 11'(len); p_base = 11'(p);
        start = 1'b1;
        exp_x.delete(); exp_p.delete(); x_obs.delete(); p_obs.delete();
        for (int k = 0; k < COL; k++) exp_x.push_back((w + k) % 2048);
        for (int k = 0; k < len; k++) exp_x.push_back((x + k) % 2048);
        for (int k = 0; k < len; k++) exp_p.push_back((p + k) % 2048);
        cur_len = len;
        n_rd = 0; n_l0w = 0; n_load = 0; n_exec = 0; n_ofrd = 0; n_pw = 0; n_done = 0;
        last_load_cyc = -1; first_x_cyc = -1; done_cyc = -1; first_exec_cyc = -1; last_exec_cyc = -1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble inputs so any sampling while busy would show up as wrong addresses.
        w_base = 11'h555; x_base = 11'h2AA; x_len = 11'd3; p_base = 11'h123;
    endtask

    task automatic wait_tile(input int budget, input int extra_at);
        for (int i = 0; i < budget && n_done == 0; i++) begin
            @(posedge clk); #1;
            start = (i == extra_at);
        end
        start = 1'b0;
        check("tile_done_in_budget", n_done > 0, 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic end_checks(input bit gapchk);
        check("read_count", n_rd, COL + cur_len);
        check("l0_wr_count", n_l0w, COL + cur_len);
        check("load_count", n_load, COL);
        check("exec_count", n_exec, cur_len);
        check("ofifo_rd_count", n_ofrd, cur_len);
        check("pmem_write_count", n_pw, cur_len);
        check("done_pulses", n_done, 1);
        check("reads_left", exp_x.size(), 0);
        check("writes_left", exp_p.size(), 0);
        check("busy_after", busy, 0);
        if (gapchk) begin
            if (cur_len > 0) check("propagation_gap", first_x_cyc - last_load_cyc, ROW + COL + 1);
            else             check("propagation_gap_done", done_cyc - last_load_cyc, ROW + COL + 1);
        end
        if (cur_len > 0) check("exec_contiguous", last_exec_cyc - first_exec_cyc, cur_len - 1);
    endtask

    initial begin
        int lit_x2[12];
        int lit_xw[4];
        int lit_pw[4];
        lit_x2 = '{0, 1, 2, 3, 4, 5, 6, 7, 16, 17, 18, 19};
        lit_xw = '{2046, 2047, 0, 1};
        lit_pw = '{2047, 0, 1, 2};

        // Reset held for three cycles, then released away from the clock edge.
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset_inst", inst, 34'h1_800C_0000);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);

        // Basic tile.
        begin_tile(0, 16, 4, 100);
        wait_tile(300, -1);
        end_checks(1);
        check("first_read_word", first_rd_word, 34'h1_8004_0000);
        check("first_pmem_word_hi", first_pw_word[33:20], 14'd100);
        check("basic_x_obs_size", x_obs.size(), 12);
        if (x_obs.size() == 12)
            for (int i = 0; i < 12; i++) check("basic_x_obs", x_obs[i], lit_x2[i]);

        // l0_ready and ofifo_valid alternating every cycle.
        l0_tog = 1'b1; ofv_tog = 1'b1;
        begin_tile(32, 40, 5, 200);
        wait_tile(600, -1);
        l0_tog = 1'b0; ofv_tog = 1'b0;
        end_checks(0);

        // No activations: kernel load then straight to done.
        begin_tile(8, 100, 0, 300);
        wait_tile(300, -1);
        end_checks(1);

        // Address wrap on weights, activations and results.
        begin_tile(2044, 2046, 4, 2047);
        wait_tile(300, -1);
        end_checks(1);
        check("wrap_x_obs_size", x_obs.size(), 12);
        if (x_obs.size() == 12) begin
            for (int i = 0; i < 4; i++) check("wrap_w_obs", x_obs[i], (2044 + i) % 2048);
            for (int i = 0; i < 4; i++) check("wrap_x_obs", x_obs[8 + i], lit_xw[i]);
        end
        check("wrap_p_obs_size", p_obs.size(), 4);
        if (p_obs.size() == 4)
            for (int i = 0; i < 4; i++) check("wrap_p_obs", p_obs[i], lit_pw[i]);

        // Reset during EXEC aborts immediately.
        begin_tile(0, 0, 20, 0);
        for (int i = 0; i < 300 && n_exec == 0; i++) @(posedge clk);
        check("reached_exec", n_exec > 0, 1);
        #3;
        reset = 1'b0;
        #1;
        check("abort_inst", inst, NOP);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        reset = 1'b1;
        repeat (3) @(posedge clk);

        // Fresh tile after abort, with a stray start pulse while busy.
        begin_tile(64, 128, 6, 500);
        wait_tile(400, 5);
        end_checks(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
